// File: rtl/matrix_feeder.sv
// ============================================================================
// Module   : matrix_feeder
// Purpose  : Buffers an upstream byte stream and delivers it to a matrix
//            multiplier, one BYTES_PER_MAT-byte X matrix per start pulse.
//            Optional macro MATRIX_FEEDER_STATS_EN enables the mat_cnt counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_feeder #(
  parameter int BYTES_PER_MAT = 32,
  parameter int FIFO_DEPTH    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       finish,
  output logic       start_in,
  output logic       valid_input,
  output logic [7:0] X_load,
  output logic       busy,
  output logic [7:0] mat_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (BYTES_PER_MAT > 1) ? $clog2(BYTES_PER_MAT) : 1;

  localparam logic [AW:0]   c_FULL      = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   c_MAT_BYTES = (AW+1)'(BYTES_PER_MAT);
  localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] c_LAST      = CW'(BYTES_PER_MAT - 1);
  localparam logic [CW-1:0] c_BYTE_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_START    = 2'd1,
    S_STREAM   = 2'd2,
    S_WAIT_FIN = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [CW-1:0]   r_byte_cnt;
  logic            r_start_in;
  logic            r_valid;
  logic [7:0]      r_x_load;
  logic            w_push;
  logic            w_pop;

  // Full is judged on stored occupancy alone, so a same-cycle pop never
  // opens the input while the buffer is at capacity.
  assign s_ready     = (r_count != c_FULL);
  assign w_push      = s_valid & s_ready;
  assign start_in    = r_start_in;
  assign valid_input = r_valid;
  assign X_load      = r_x_load;
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count >= c_MAT_BYTES) w_next = S_START;
      end
      S_START: begin
        w_next = S_STREAM;
        w_pop  = 1'b1;
      end
      S_STREAM: begin
        if (r_byte_cnt == c_LAST) w_next = S_WAIT_FIN;
        else                      w_pop  = 1'b1;
      end
      S_WAIT_FIN: begin
        if (finish) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_STREAM && r_byte_cnt != c_LAST) r_byte_cnt <= r_byte_cnt + c_BYTE_ONE;
      else                                             r_byte_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_in <= 1'b0;
      r_valid    <= 1'b0;
      r_x_load   <= 8'd0;
    end else begin
      r_start_in <= (w_next == S_START);
      r_valid    <= w_pop;
      r_x_load   <= w_pop ? r_mem[r_rd_ptr] : 8'd0;
    end
  end

`ifdef MATRIX_FEEDER_STATS_EN
  logic [7:0] r_mat_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mat_cnt <= 8'd0;
    end else if (r_state == S_STREAM && w_next == S_WAIT_FIN) begin
      r_mat_cnt <= r_mat_cnt + 8'd1;
    end
  end

  assign mat_cnt = r_mat_cnt;
`else
  assign mat_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_feeder.sv
// ============================================================================
// Module   : tb_matrix_feeder
// Purpose  : Directed self-checking bench for matrix_feeder with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_feeder;

  localparam int BPM   = 32;
  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_ready;
  logic       finish = 1'b0;
  logic       start_in;
  logic       valid_input;
  logic [7:0] X_load;
  logic       busy;
  logic [7:0] mat_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  matrix_feeder #(.BYTES_PER_MAT(BPM), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .finish(finish), .start_in(start_in), .valid_input(valid_input),
    .X_load(X_load), .busy(busy), .mat_cnt(mat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: byte queue plus a phase count measured from the start pulse.
  // phase -1 idle, 0 start pulse, 1..BPM streaming byte phase-1, BPM+1 waiting.
  logic [7:0] m_q[$];
  int         m_phase = -1;
  logic [7:0] m_x = 8'd0;
  logic [7:0] m_mat = 8'd0;

  always @(posedge clk or posedge rst) begin : model
    int  sz;
    bit  push;
    if (rst) begin
      m_q.delete();
      m_phase = -1;
      m_x     = 8'd0;
      m_mat   = 8'd0;
    end else begin
      sz   = m_q.size();
      push = s_valid && (sz != DEPTH);
      if (m_phase == -1) begin
        if (sz >= BPM) m_phase = 0;
      end else if (m_phase < BPM) begin
        m_x = m_q.pop_front();
        m_phase++;
      end else if (m_phase == BPM) begin
        m_phase = BPM + 1;
`ifdef MATRIX_FEEDER_STATS_EN
        m_mat = m_mat + 8'd1;
`endif
      end else if (finish) begin
        m_phase = -1;
      end
      if (push) m_q.push_back(s_data);
    end
  end

  always @(negedge clk) begin : compare
    bit ev;
    if (chk_en) begin
      ev = (m_phase >= 1) && (m_phase <= BPM);
      check("mdl_start",  start_in,    (m_phase == 0) ? 1 : 0);
      check("mdl_valid",  valid_input, ev ? 1 : 0);
      check("mdl_xload",  X_load,      ev ? m_x : 0);
      check("mdl_busy",   busy,        (m_phase != -1) ? 1 : 0);
      check("mdl_sready", s_ready,     (m_q.size() != DEPTH) ? 1 : 0);
      check("mdl_matcnt", mat_cnt,     m_mat);
    end
  end

  task automatic push_byte(input logic [7:0] d);
    int t;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("push_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic push_range(input int base, input int n);
    for (int i = 0; i < n; i++) push_byte(8'(base + i));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_start(input int bound, input string name);
    int t;
    t = 0;
    while (!start_in && t < bound) begin
      @(negedge clk);
      t++;
    end
    check(name, start_in, 1);
  endtask

  // Called at the negedge showing start_in; checks the following BPM bytes.
  task automatic stream_check(input int base, input string name);
    for (int i = 0; i < BPM; i++) begin
      @(negedge clk);
      check({name, "_v"}, valid_input, 1);
      check({name, "_x"}, X_load, (base + i) & 8'hFF);
    end
    @(negedge clk);
    check({name, "_end_v"}, valid_input, 0);
    check({name, "_end_busy"}, busy, 1);
  endtask

  task automatic pulse_finish();
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_start", start_in, 0);
    check("rst_valid", valid_input, 0);
    check("rst_xload", X_load, 0);
    check("rst_busy",  busy, 0);
    check("rst_mat",   mat_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sready", s_ready, 1);
  endtask

  initial begin
    int starts;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    do_reset();

    // Back-to-back 0..31: start two negedges after the final push edge.
    push_range(0, BPM);
    check("t30_nostart_yet", start_in, 0);
    check("t30_idle", busy, 0);
    @(negedge clk);
    check("t30_start", start_in, 1);
    stream_check(0, "t30");
    repeat (4) @(negedge clk);
    check("t30_hold_busy", busy, 1);
    pulse_finish();
    check("t30_fin_idle", busy, 0);

    // Finish asserted mid-stream must be ignored.
    push_range(100, BPM);
    wait_start(5, "t33_start");
    for (int i = 0; i < BPM; i++) begin
      @(negedge clk);
      if (i == 0) finish = 1'b1;
      if (i == 6) finish = 1'b0;
      check("t33_v", valid_input, 1);
      check("t33_x", X_load, 100 + i);
    end
    repeat (3) @(negedge clk);
    check("t33_wait_busy", busy, 1);
    pulse_finish();

    // Fill to capacity with the multiplier stalled, then drain two matrices.
    do_reset();
    push_range(0, 3 * BPM);
    check("t31_full", s_ready, 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    check("t31_full_hold", s_ready, 0);
    pulse_finish();
    check("t31_gap_idle", start_in, 0);
    @(negedge clk);
    check("t31_start2", start_in, 1);
    stream_check(32, "t31b");
    check("t31_ready_again", s_ready, 1);
    pulse_finish();
    wait_start(3, "t31_start3");
    stream_check(64, "t31c");
    pulse_finish();
`ifdef MATRIX_FEEDER_STATS_EN
    check("t35_matcnt", mat_cnt, 3);
`else
    check("t35_matcnt", mat_cnt, 0);
`endif

    // Partial matrix stays parked.
    push_range(40, 20);
    starts = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_in) starts++;
    end
    check("t32_no_start", starts, 0);
    push_range(60, 12);
    wait_start(3, "t32_start");
    stream_check(40, "t32");
    pulse_finish();

    // Asynchronous reset at the 10th streamed byte.
    push_range(150, BPM);
    wait_start(3, "t34_start");
    repeat (10) @(posedge clk);
    #1;
    check("t34_pre_x", X_load, 159);
    #1;
    rst = 1'b1;
    #1;
    check("t34_rst_v", valid_input, 0);
    check("t34_rst_x", X_load, 0);
    check("t34_rst_busy", busy, 0);
    check("t34_rst_sready", s_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    push_range(200, BPM - 1);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start_in) starts++;
    end
    check("t34_flushed", starts, 0);
    push_range(231, 1);
    wait_start(3, "t34_start2");
    stream_check(200, "t34");
    pulse_finish();

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
